clk_tick_recovery: RTL and testbench

Fast-domain receiver for a slow, free-running divided clock, such as the output of a ripple T-flip-flop divider chain.
- Brings the slow clock into the `clk` domain through a synchronizer.
- Converts each rising edge into a single-cycle `tick`.
- Measures the slow-clock period in `clk` cycles.
- Flags loss of the slow clock with a timeout.

Downstream logic uses `tick` as a clean clock enable instead of clocking flops from a divided net.

---
 rtl/clk_tick_recovery.sv | 114 +++++++++++
 tb/tb_clk_tick_recovery.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/clk_tick_recovery.sv
// Recovers a slow free-running clock into the clk domain: synchronizes it, emits a one-cycle
// tick per rising edge, measures the rising-to-rising period and flags loss of the slow clock.
module clk_tick_recovery #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TIMEOUT     = 2 ** 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             lost,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StLocked = 2'd2,
    StLost   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TimeoutM1  = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_d_q, s_d_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   tick_q, tick_d;
  logic                   valid_q, valid_d;
  logic                   lost_q, lost_d;
  state_e                 state_q, state_d;

  logic s;
  logic rise;
  logic timeout;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign timeout = (cnt_q == TimeoutM1) && !rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
    s_d_d  = s;
  end

  // Counter saturates at TIMEOUT so a stalled slow clock can never wrap into a bogus period.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TimeoutVal) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A rise wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      unique case (state_q)
        StIdle:   state_d = StArmed;
        StArmed:  state_d = StLocked;
        StLocked: state_d = StLocked;
        StLost:   state_d = StArmed;
        default:  state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d = StLost;
    end
  end

  always_comb begin
    period_d = period_q;
    if (rise && (state_q == StArmed || state_q == StLocked)) begin
      period_d = cnt_q;
    end
    tick_d  = rise;
    valid_d = (state_d == StLocked);
    lost_d  = (state_d == StLost);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
      state_q  <= StIdle;
    end else begin
      sync_q   <= sync_d;
      s_d_q    <= s_d_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
      state_q  <= state_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign lost         = lost_q;
  assign state        = state_q;

endmodule

// File: tb/tb_clk_tick_recovery.sv
// Directed bench for clk_tick_recovery: SYNC_STAGES=2, CNT_W=8, TIMEOUT=200.
module tb_clk_tick_recovery;

  logic       clk = 1'b0;
  logic       reset;
  logic       slow_clk_in;
  logic       tick;
  logic [7:0] period;
  logic       period_valid;
  logic       lost;
  logic [1:0] state;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int tick_cnt  = 0;
  int last_tick = 0;
  int prev_tick = 0;
  int rise_cyc  = 0;
  int lost_cyc  = 0;
  bit lost_ever = 1'b0;
  bit pv_drop   = 1'b0;

  clk_tick_recovery #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .TIMEOUT    (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .tick        (tick),
    .period      (period),
    .period_valid(period_valid),
    .lost        (lost),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and record what the outputs show there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tick === 1'b1) begin
      tick_cnt++;
      prev_tick = last_tick;
      last_tick = cyc;
    end
    if (lost === 1'b1) begin
      lost_ever = 1'b1;
      if (lost_cyc == 0) lost_cyc = cyc;
    end
    if (period_valid !== 1'b1) pv_drop = 1'b1;
  endtask

  task automatic slow_period(input int hi, input int lo);
    slow_clk_in = 1'b1;
    rise_cyc    = cyc;
    repeat (hi) step();
    slow_clk_in = 1'b0;
    repeat (lo) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    slow_clk_in = 1'b0;

    // Reset held with the slow clock toggling.
    for (int i = 0; i < 5; i++) begin
      slow_clk_in = ~slow_clk_in;
      step();
      chk("rst_outs", 32'({tick, period_valid, lost, state, period}), 32'd0);
    end
    reset       = 1'b1;
    slow_clk_in = 1'b0;
    tick_cnt    = 0;
    repeat (5) step();
    chk("idle_no_tick", 32'(tick_cnt), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // Lock-up on a 40-cycle square wave.
    slow_period(20, 20);
    chk("first_tick_count", 32'(tick_cnt), 32'd1);
    chk("first_tick_latency", 32'(last_tick - rise_cyc), 32'd3);
    chk("armed_state", 32'(state), 32'd1);
    chk("armed_valid", 32'(period_valid), 32'd0);
    chk("armed_period", 32'(period), 32'd0);
    slow_period(20, 20);
    chk("lock_state", 32'(state), 32'd2);
    chk("lock_valid", 32'(period_valid), 32'd1);
    chk("lock_period", 32'(period), 32'd40);
    chk("lock_gap", 32'(last_tick - prev_tick), 32'd40);
    pv_drop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slow_period(20, 20);
      chk("steady_period", 32'(period), 32'd40);
      chk("steady_gap", 32'(last_tick - prev_tick), 32'd40);
    end
    chk("tick_count_40", 32'(tick_cnt), 32'd4);

    // Period change to 60 while locked.
    slow_period(30, 30);
    chk("chg_first_still40", 32'(period), 32'd40);
    slow_period(30, 30);
    chk("chg_period60_range", 32'(period >= 8'd59 && period <= 8'd61), 32'd1);
    slow_period(30, 30);
    chk("chg_period60", 32'(period), 32'd60);
    chk("chg_gap60", 32'(last_tick - prev_tick), 32'd60);
    chk("chg_valid_held", 32'(pv_drop), 32'd0);

    // Loss: slow clock held low.
    lost_cyc  = 0;
    lost_ever = 1'b0;
    repeat (250) step();
    chk("lost_seen", 32'(lost_ever), 32'd1);
    chk("lost_delay", 32'(lost_cyc - last_tick), 32'd199);
    chk("lost_flag", 32'(lost), 32'd1);
    chk("lost_state", 32'(state), 32'd3);
    chk("lost_valid", 32'(period_valid), 32'd0);
    chk("lost_stale_period", 32'(period), 32'd60);
    chk("lost_cnt_sat", 32'(dut.cnt_q), 32'd200);

    // Recovery.
    slow_period(20, 20);
    chk("rec_state_armed", 32'(state), 32'd1);
    chk("rec_lost_clear", 32'(lost), 32'd0);
    chk("rec_valid_low", 32'(period_valid), 32'd0);
    chk("rec_period_stale", 32'(period), 32'd60);
    slow_period(20, 20);
    chk("rec_state_locked", 32'(state), 32'd2);
    chk("rec_valid", 32'(period_valid), 32'd1);
    chk("rec_period", 32'(period), 32'd40);

    // Rise coinciding with cnt == TIMEOUT-1.
    lost_ever = 1'b0;
    slow_period(100, 99);
    slow_period(20, 20);
    chk("edge_period199", 32'(period), 32'd199);
    chk("edge_state", 32'(state), 32'd2);
    chk("edge_no_lost", 32'(lost_ever), 32'd0);

    // One-cycle reset while locked.
    reset = 1'b0;
    step();
    chk("mid_rst_outs", 32'({tick, period_valid, lost, state, period}), 32'd0);
    reset = 1'b1;
    slow_period(20, 20);
    chk("relock_armed", 32'(state), 32'd1);
    chk("relock_armed_valid", 32'(period_valid), 32'd0);
    slow_period(20, 20);
    chk("relock_locked", 32'(state), 32'd2);
    chk("relock_valid", 32'(period_valid), 32'd1);
    chk("relock_period", 32'(period), 32'd40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
